// File: rtl/mul_operand_sequencer_if.sv
// Handshake and datapath bundle for mul_operand_sequencer.
// The slave modport is the sequencer's view; master is the environment driving it.
interface mul_operand_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [15:0] mul_data;
    logic        mul_start;
    logic        mul_done;
    logic [15:0] mul_y;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_p;
    logic        out_err;
    logic        busy;

    modport slave (
        input  in_valid, in_a, in_b, mul_done, mul_y, out_ready,
        output in_ready, mul_data, mul_start, out_valid, out_p, out_err, busy
    );

    modport master (
        output in_valid, in_a, in_b, mul_done, mul_y, out_ready,
        input  in_ready, mul_data, mul_start, out_valid, out_p, out_err, busy
    );
endinterface

// File: rtl/mul_operand_sequencer.sv
// Feeds an operand pair serially to a repeated-addition multiplier and holds its product.
// Optional RUN-state abort timer is built only when MUL_SEQ_TIMEOUT_EN is defined.
module mul_operand_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mul_operand_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_A = 3'd1,
        ST_LOAD_B = 3'd2,
        ST_RUN    = 3'd3,
        ST_HOLD   = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [15:0] mul_data_q, mul_data_d;
    logic        mul_start_q, mul_start_d;
    logic        out_valid_q, out_valid_d;
    logic [15:0] out_p_q, out_p_d;
    logic        busy_q, busy_d;

`ifdef MUL_SEQ_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc_s;
    logic             out_err_q, out_err_d;

    assign cnt_inc_s = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
`endif

    // Next-state, operand latching and result capture
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        out_p_d = out_p_q;
`ifdef MUL_SEQ_TIMEOUT_EN
        cnt_d     = cnt_q;
        out_err_d = out_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    state_d = ST_LOAD_A;
                    a_d     = bus.in_a;
                    b_d     = bus.in_b;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD_A: state_d = ST_LOAD_B;
            ST_LOAD_B: begin
                state_d = ST_RUN;
`ifdef MUL_SEQ_TIMEOUT_EN
                cnt_d = '0;
`endif
            end
            ST_RUN: begin
                // A completion landing on the deadline cycle still counts as success
                if (bus.mul_done) begin
                    state_d = ST_HOLD;
                    out_p_d = bus.mul_y;
`ifdef MUL_SEQ_TIMEOUT_EN
                    out_err_d = 1'b0;
`endif
                end else begin
`ifdef MUL_SEQ_TIMEOUT_EN
                    cnt_d = cnt_inc_s;
                    if (cnt_inc_s == CNT_LIMIT) begin
                        state_d   = ST_HOLD;
                        out_p_d   = 16'd0;
                        out_err_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
`else
                    state_d = ST_RUN;
`endif
                end
            end
            ST_HOLD: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output values for the coming cycle, decoded from the next state
    always_comb begin
        mul_data_d  = 16'd0;
        mul_start_d = 1'b0;
        case (state_d)
            ST_LOAD_A: begin
                mul_data_d  = a_d;
                mul_start_d = 1'b1;
            end
            ST_LOAD_B: begin
                mul_data_d  = b_d;
                mul_start_d = 1'b1;
            end
            default: begin
                mul_data_d  = 16'd0;
                mul_start_d = 1'b0;
            end
        endcase
        out_valid_d = (state_d == ST_HOLD);
        busy_d      = (state_d != ST_IDLE);
    end

    // State and output registers; reset discards any multiplication in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            a_q         <= 16'd0;
            b_q         <= 16'd0;
            mul_data_q  <= 16'd0;
            mul_start_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_p_q     <= 16'd0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            mul_data_q  <= mul_data_d;
            mul_start_q <= mul_start_d;
            out_valid_q <= out_valid_d;
            out_p_q     <= out_p_d;
            busy_q      <= busy_d;
        end
    end

`ifdef MUL_SEQ_TIMEOUT_EN
    // Abort timer and error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            out_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            out_err_q <= out_err_d;
        end
    end

    assign bus.out_err = out_err_q;
`else
    assign bus.out_err = 1'b0;
`endif

    // in_ready is gated by rst_n so it is low while reset is held and high right after release
    assign bus.in_ready  = rst_n & (state_q == ST_IDLE);
    assign bus.mul_data  = mul_data_q;
    assign bus.mul_start = mul_start_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_p     = out_p_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mul_operand_sequencer.sv
// Directed self-checking bench for mul_operand_sequencer; the tb plays the multiplier controller.
// Build with MUL_SEQ_TIMEOUT_EN defined to exercise the abort timer (TIMEOUT_CYCLES = 8).
module tb_mul_operand_sequencer;

    logic clk;
    logic rst_n;
    int   vec_cnt;
    int   err_cnt;

    mul_operand_sequencer_if bus ();

    mul_operand_sequencer #(.TIMEOUT_CYCLES(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Accept a pair and advance to the first RUN cycle
    task automatic start_pair(input logic [15:0] a, input logic [15:0] b);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        cyc();
        bus.in_valid = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        vec_cnt++; if (bus.in_ready !== 1'b0) begin err_cnt++; $display("FAIL reset_in_ready: got %0d expected 0", bus.in_ready); end
        vec_cnt++; if (bus.busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy: got %0d expected 0", bus.busy); end
        vec_cnt++; if (bus.mul_start !== 1'b0 || bus.mul_data !== 16'd0) begin err_cnt++; $display("FAIL reset_mul: got start=%0d data=%0d expected 0/0", bus.mul_start, bus.mul_data); end
        vec_cnt++; if (bus.out_valid !== 1'b0 || bus.out_p !== 16'd0 || bus.out_err !== 1'b0) begin err_cnt++; $display("FAIL reset_out: got v=%0d p=%0d e=%0d expected 0/0/0", bus.out_valid, bus.out_p, bus.out_err); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        vec_cnt++; if (bus.in_ready !== 1'b1) begin err_cnt++; $display("FAIL release_in_ready: got %0d expected 1", bus.in_ready); end
    endtask

    task automatic test_basic();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_a      = 16'd17;
        bus.in_b      = 16'd5;
        cyc();
        bus.in_valid = 1'b0;
        vec_cnt++; if (bus.mul_data !== 16'd17 || bus.mul_start !== 1'b1) begin err_cnt++; $display("FAIL basic_load_a: got data=%0d start=%0d expected 17/1", bus.mul_data, bus.mul_start); end
        vec_cnt++; if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin err_cnt++; $display("FAIL basic_busy: got ready=%0d busy=%0d expected 0/1", bus.in_ready, bus.busy); end
        cyc();
        vec_cnt++; if (bus.mul_data !== 16'd5 || bus.mul_start !== 1'b1) begin err_cnt++; $display("FAIL basic_load_b: got data=%0d start=%0d expected 5/1", bus.mul_data, bus.mul_start); end
        cyc();
        vec_cnt++; if (bus.mul_data !== 16'd0 || bus.mul_start !== 1'b0) begin err_cnt++; $display("FAIL basic_run: got data=%0d start=%0d expected 0/0", bus.mul_data, bus.mul_start); end
        cyc();
        vec_cnt++; if (bus.out_valid !== 1'b0) begin err_cnt++; $display("FAIL basic_run2_valid: got %0d expected 0", bus.out_valid); end
        bus.mul_done = 1'b1;
        bus.mul_y    = 16'd85;
        cyc();
        bus.mul_done = 1'b0;
        vec_cnt++; if (bus.out_valid !== 1'b1 || bus.out_p !== 16'd85 || bus.out_err !== 1'b0) begin err_cnt++; $display("FAIL basic_result: got v=%0d p=%0d e=%0d expected 1/85/0", bus.out_valid, bus.out_p, bus.out_err); end
        cyc();
        vec_cnt++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin err_cnt++; $display("FAIL basic_idle: got v=%0d ready=%0d busy=%0d expected 0/1/0", bus.out_valid, bus.in_ready, bus.busy); end
    endtask

    task automatic test_zero();
        bus.out_ready = 1'b1;
        start_pair(16'd0, 16'd9);
        bus.mul_done = 1'b1;
        bus.mul_y    = 16'd0;
        cyc();
        bus.mul_done = 1'b0;
        vec_cnt++; if (bus.out_valid !== 1'b1 || bus.out_p !== 16'd0) begin err_cnt++; $display("FAIL zero_result: got v=%0d p=%0d expected 1/0", bus.out_valid, bus.out_p); end
        cyc();
        vec_cnt++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin err_cnt++; $display("FAIL zero_one_cycle: got v=%0d ready=%0d expected 0/1", bus.out_valid, bus.in_ready); end
    endtask

    task automatic test_backpressure();
        int bad;
        bus.out_ready = 1'b0;
        start_pair(16'd17, 16'd5);
        bus.mul_done = 1'b1;
        bus.mul_y    = 16'd85;
        cyc();
        bus.mul_done = 1'b0;
        bus.mul_y    = 16'd1;
        bus.in_valid = 1'b1;
        bus.in_a     = 16'd2;
        bus.in_b     = 16'd3;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.out_valid !== 1'b1 || bus.out_p !== 16'd85 || bus.in_ready !== 1'b0) bad++;
            cyc();
        end
        vec_cnt++; if (bad != 0) begin err_cnt++; $display("FAIL bp_hold: got %0d bad cycles expected 0", bad); end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        vec_cnt++; if (bus.out_valid !== 1'b1 || bus.out_p !== 16'd85) begin err_cnt++; $display("FAIL bp_last: got v=%0d p=%0d expected 1/85", bus.out_valid, bus.out_p); end
        cyc();
        vec_cnt++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin err_cnt++; $display("FAIL bp_release: got v=%0d busy=%0d expected 0/0", bus.out_valid, bus.busy); end
    endtask

    task automatic test_ignore_in_valid();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_a      = 16'd17;
        bus.in_b      = 16'd5;
        cyc();
        bus.in_a     = 16'd7;
        bus.in_b     = 16'd3;
        bus.mul_done = 1'b1;
        bus.mul_y    = 16'd55;
        cyc();
        vec_cnt++; if (bus.mul_data !== 16'd5 || bus.mul_start !== 1'b1 || bus.out_valid !== 1'b0) begin err_cnt++; $display("FAIL ign_load_b: got data=%0d start=%0d v=%0d expected 5/1/0", bus.mul_data, bus.mul_start, bus.out_valid); end
        bus.mul_done = 1'b0;
        repeat (3) cyc();
        vec_cnt++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin err_cnt++; $display("FAIL ign_run: got v=%0d ready=%0d expected 0/0", bus.out_valid, bus.in_ready); end
        bus.mul_done = 1'b1;
        bus.mul_y    = 16'd85;
        bus.in_valid = 1'b0;
        cyc();
        bus.mul_done = 1'b0;
        vec_cnt++; if (bus.out_valid !== 1'b1 || bus.out_p !== 16'd85) begin err_cnt++; $display("FAIL ign_result: got v=%0d p=%0d expected 1/85", bus.out_valid, bus.out_p); end
        cyc();
    endtask

    task automatic test_reset_mid_run();
        bus.out_ready = 1'b1;
        start_pair(16'd17, 16'd5);
        cyc();
        #2;
        rst_n = 1'b0;
        #1;
        vec_cnt++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_p !== 16'd0 || bus.mul_start !== 1'b0 || bus.mul_data !== 16'd0) begin err_cnt++; $display("FAIL rst_async: got busy=%0d v=%0d p=%0d start=%0d data=%0d expected all 0", bus.busy, bus.out_valid, bus.out_p, bus.mul_start, bus.mul_data); end
        bus.mul_done = 1'b1;
        bus.mul_y    = 16'd99;
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
        vec_cnt++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin err_cnt++; $display("FAIL rst_done_ignored: got v=%0d busy=%0d ready=%0d expected 0/0/1", bus.out_valid, bus.busy, bus.in_ready); end
        bus.mul_done = 1'b0;
        start_pair(16'd3, 16'd4);
        bus.mul_done = 1'b1;
        bus.mul_y    = 16'd12;
        cyc();
        bus.mul_done = 1'b0;
        vec_cnt++; if (bus.out_valid !== 1'b1 || bus.out_p !== 16'd12) begin err_cnt++; $display("FAIL rst_next_pair: got v=%0d p=%0d expected 1/12", bus.out_valid, bus.out_p); end
        cyc();
    endtask

    task automatic test_run_limit();
        bus.out_ready = 1'b1;
`ifdef MUL_SEQ_TIMEOUT_EN
        start_pair(16'd6, 16'd7);
        repeat (7) cyc();
        vec_cnt++; if (bus.out_valid !== 1'b0) begin err_cnt++; $display("FAIL to_early: got v=%0d expected 0", bus.out_valid); end
        cyc();
        vec_cnt++; if (bus.out_valid !== 1'b1 || bus.out_err !== 1'b1 || bus.out_p !== 16'd0) begin err_cnt++; $display("FAIL to_abort: got v=%0d e=%0d p=%0d expected 1/1/0", bus.out_valid, bus.out_err, bus.out_p); end
        cyc();
        start_pair(16'd6, 16'd7);
        repeat (7) cyc();
        bus.mul_done = 1'b1;
        bus.mul_y    = 16'd42;
        cyc();
        bus.mul_done = 1'b0;
        vec_cnt++; if (bus.out_valid !== 1'b1 || bus.out_err !== 1'b0 || bus.out_p !== 16'd42) begin err_cnt++; $display("FAIL to_done_wins: got v=%0d e=%0d p=%0d expected 1/0/42", bus.out_valid, bus.out_err, bus.out_p); end
        cyc();
`else
        start_pair(16'd6, 16'd7);
        repeat (20) cyc();
        vec_cnt++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b1) begin err_cnt++; $display("FAIL wait_forever: got v=%0d busy=%0d expected 0/1", bus.out_valid, bus.busy); end
        bus.mul_done = 1'b1;
        bus.mul_y    = 16'd1234;
        cyc();
        bus.mul_done = 1'b0;
        vec_cnt++; if (bus.out_valid !== 1'b1 || bus.out_err !== 1'b0 || bus.out_p !== 16'd1234) begin err_cnt++; $display("FAIL wait_result: got v=%0d e=%0d p=%0d expected 1/0/1234", bus.out_valid, bus.out_err, bus.out_p); end
        cyc();
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        clk           = 1'b0;
        rst_n         = 1'b0;
        vec_cnt       = 0;
        err_cnt       = 0;
        bus.in_valid  = 1'b0;
        bus.in_a      = 16'd0;
        bus.in_b      = 16'd0;
        bus.mul_done  = 1'b0;
        bus.mul_y     = 16'd0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_zero();
        test_backpressure();
        test_ignore_in_valid();
        test_reset_mid_run();
        test_run_limit();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/mul_operand_sequencer.md
MUL_OPERAND_SEQUENCER -- requirements
Module: mul_operand_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1023, RUN-state cycle limit before abort (used only when MUL_SEQ_TIMEOUT_EN is defined).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  operand pair offered.
REQ-005 in_ready  output  1  sequencer accepts a pair this cycle.
REQ-006 in_a  input  16  multiplicand.
REQ-007 in_b  input  16  multiplier (repeat count).
REQ-008 mul_data  output  16  serial operand bus to the repeated-addition datapath.
REQ-009 mul_start  output  1  start request to the multiplier controller.
REQ-010 mul_done  input  1  completion flag from the multiplier controller.
REQ-011 mul_y  input  16  product register of the multiplier datapath.
REQ-012 out_valid  output  1  result available.
REQ-013 out_ready  input  1  consumer accepts result.
REQ-014 out_p  output  16  captured product.
REQ-015 out_err  output  1  result aborted by timeout; qualified by out_valid.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 FSM states IDLE, LOAD_A, LOAD_B, RUN, HOLD; exactly one active at a time.
REQ-018 in_ready SHALL be 1 only in IDLE; in_valid outside IDLE is ignored, with no buffering.
REQ-019 IDLE: in_valid && in_ready registers in_a/in_b and moves to LOAD_A next edge.
REQ-020 LOAD_A: mul_data = latched A, mul_start = 1, one cycle, then LOAD_B.
REQ-021 LOAD_B: mul_data = latched B, mul_start = 1, one cycle, then RUN.
REQ-022 RUN: mul_start = 0, mul_data = 0; on mul_done = 1, out_p <= mul_y, out_err <= 0, go to HOLD.
REQ-023 mul_done SHALL be ignored in every state except RUN.
REQ-024 HOLD: out_valid = 1; out_p/out_err stable until out_valid && out_ready, then IDLE next edge.
REQ-025 No back-to-back overlap: new pair earliest accepted the cycle after HOLD exits (one IDLE bubble).
REQ-026 Latency: accept edge to out_valid = 3 cycles + multiplier run time (cycles in RUN until mul_done).
REQ-027 Product is 16 bits; mul_y captured verbatim, no overflow detection, upper bits lost.
REQ-028 mul_data SHALL be 0 in IDLE, RUN, HOLD.

Reset
REQ-029 rst_n low SHALL immediately force IDLE regardless of clk, including mid-RUN.
REQ-030 Reset values: in_ready 0 while rst_n low, 1 in the first cycle after release; mul_data 0, mul_start 0, out_valid 0, out_p 0, out_err 0, busy 0; latched operands 0; timeout counter 0.
REQ-031 A multiplication in flight at reset is discarded; no result emitted.

Configuration
REQ-032 Macro MUL_SEQ_TIMEOUT_EN defined: counter clears on RUN entry and increments each RUN cycle; when it reaches TIMEOUT_CYCLES without mul_done, go to HOLD with out_p = 0, out_err = 1.
REQ-033 mul_done in the same cycle the counter reaches TIMEOUT_CYCLES SHALL win: normal result, out_err = 0.
REQ-034 Macro undefined: no counter is built, out_err is tied 0, and RUN waits for mul_done indefinitely.

Verification
REQ-035 in_a=17, in_b=5, out_ready=1 -> mul_data 17 then 5 with mul_start high two cycles; out_p=85, out_err=0.
REQ-036 in_a=0, in_b=9 -> out_p=0, out_valid one cycle, then in_ready=1.
REQ-037 17x5 with out_ready low for 10 cycles -> out_valid and out_p=85 held 10 cycles; in_ready=0 throughout.
REQ-038 rst_n pulsed low 2 cycles into RUN -> all outputs 0 asynchronously; later mul_done ignored; next pair 3x4 yields 12.
REQ-039 MUL_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=8, mul_done never asserted -> out_valid with out_err=1, out_p=0 after 8 RUN cycles.
REQ-040 in_valid held high during RUN with different operands -> ignored; original result delivered unchanged.
